// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
//
// Holds the receiver state enumeration, the data width and the default
// line/clock rates used as parameter defaults by uart_rx and uart_rx_tick.

package uart_pkg;

    // Number of data bits in an 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Default serial bit rate (bits/s) and system clock frequency (Hz).
    localparam int DEFAULT_BAUD_RATE  = 57_600;
    localparam int DEFAULT_CLOCK_RATE = 50_000_000;

    // Default number of sample ticks per bit; must be even and >= 4.
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Receiver frame states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - oversample tick generator for the UART receiver
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   clear in  hold the down-counter at its reload value
//   run   in  let the down-counter run
//   tick  out one-clk pulse each time the running counter reaches zero
//
// The divider is CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) with integer truncation,
// clamped to at least 1 so extreme parameter choices still elaborate.

module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // clear wins over run so the counter is parked at the reload value
    // while the receiver waits for a start edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = RELOAD;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !clear && (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first UART receiver with oversampled bit timing
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   rx_in         in   serial line, asynchronous to clk, idle high
//   rx_data       out  last received byte
//   rx_data_valid out  rx_data holds a byte not yet acknowledged
//   rx_data_ack   in   consumer accepts rx_data (only while valid is high)
//   frame_err     out  one-clk pulse: stop bit sampled low
//   overrun_err   out  one-clk pulse: byte completed while valid still high
//   busy          out  receiver is in any state other than IDLE

module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_data_valid,
    input  logic                      rx_data_ack,
    output logic                      frame_err,
    output logic                      overrun_err,
    output logic                      busy
);

    localparam int IW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [IW-1:0] HALF_LAST = IW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] FULL_LAST = IW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    // Two-flop synchronizer; both flops reset to the idle (high) level so a
    // frame is only picked up from a genuine falling edge after reset.
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rx_s = sync_q[1];

    uart_rx_state_e            state_q;
    logic [IW-1:0]             tick_idx_q;
    logic [BW-1:0]             bit_cnt_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] rx_data_q;
    logic                      valid_q;
    logic                      frame_err_q;
    logic                      overrun_err_q;
    logic                      busy_q;

    logic tick;
    logic tick_clear;
    logic tick_run;

    // Counter is parked in IDLE so the first tick after a start edge lands
    // exactly DIV clocks later; it runs freely in every other state.
    assign tick_clear = (state_q == ST_IDLE);
    assign tick_run   = (state_q != ST_IDLE);

    uart_rx_tick #(
        .BAUD_RATE  (BAUD_RATE),
        .CLOCK_RATE (CLOCK_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .run   (tick_run),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tick_idx_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Error flags are single-clock pulses by construction.
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;

            // Consume the held byte; a byte completing on this same clock
            // re-asserts valid further down and takes precedence.
            if (valid_q && rx_data_ack) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q    <= ST_START;
                        tick_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end

                // Re-check the start bit at mid-bit to reject short glitches.
                ST_START: begin
                    if (tick) begin
                        if (tick_idx_q == HALF_LAST) begin
                            tick_idx_q <= '0;
                            if (!rx_s) begin
                                state_q   <= ST_DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_idx_q <= tick_idx_q + IW'(1);
                        end
                    end
                end

                // Sampling point stays at mid-bit: one full bit after the
                // mid-start sample, then one full bit per data bit.
                ST_DATA: begin
                    if (tick) begin
                        if (tick_idx_q == FULL_LAST) begin
                            tick_idx_q <= '0;
                            shift_q    <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end else begin
                            tick_idx_q <= tick_idx_q + IW'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (tick_idx_q == FULL_LAST) begin
                            tick_idx_q <= '0;
                            if (rx_s) begin
                                state_q   <= ST_IDLE;
                                busy_q    <= 1'b0;
                                rx_data_q <= shift_q;
                                valid_q   <= 1'b1;
                                // An ack on this clock frees the slot, so
                                // the overwrite is not an overrun.
                                overrun_err_q <= valid_q && !rx_data_ack;
                            end else begin
                                state_q     <= ST_BREAK;
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            tick_idx_q <= tick_idx_q + IW'(1);
                        end
                    end
                end

                // Line held low past the stop bit: wait for it to go idle so
                // the tail of a break is not mistaken for a new start bit.
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign frame_err     = frame_err_q;
    assign overrun_err   = overrun_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

module tb_uart_rx;

    localparam int CLOCK_RATE = 6_400_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 64;
    // 2 sync flops + 1 detect clk + half bit (32) + 8 data bits + stop bit.
    localparam int VALID_LAT  = 2 + 1 + 32 + 8 * 64 + 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ack = 1'b0;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int t_start = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_dbl = 0;
    int ov_dbl = 0;
    int busy_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_fe = 1'b0;
    logic prev_ov = 1'b0;
    logic [7:0] rx_log[$];

    uart_rx #(
        .BAUD_RATE  (BAUD_RATE),
        .CLOCK_RATE (CLOCK_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ack   (rx_data_ack),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge; log each byte as it is delivered.
    always @(negedge clk) begin
        prev_valid <= rx_data_valid;
        prev_fe    <= frame_err;
        prev_ov    <= overrun_err;
        if (rx_data_valid && !prev_valid) begin
            rx_log.push_back(rx_data);
            rise_cyc <= cyc;
        end else if (overrun_err) begin
            rx_log.push_back(rx_data);
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun_err) ov_cnt <= ov_cnt + 1;
        if (frame_err && prev_fe) fe_dbl <= fe_dbl + 1;
        if (overrun_err && prev_ov) ov_dbl <= ov_dbl + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; holds rx_in for n clocks.
    task automatic line_hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int p, input int stop_low);
        t_start = cyc;
        line_hold(1'b0, p);
        for (int i = 0; i < 8; i++) line_hold(b[i], p);
        if (stop_low > 0) line_hold(1'b0, stop_low * p);
        line_hold(1'b1, 3 * p);
    endtask

    task automatic do_ack();
        rx_data_ack = 1'b1;
        @(negedge clk);
        rx_data_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int fe0;
        int ov0;
        int b0;
        int periods[2];
        logic [7:0] pats[2];
        periods[0] = 62;
        periods[1] = 66;
        pats[0] = 8'h55;
        pats[1] = 8'hAA;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_data_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ov", overrun_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean frame 0xA5 and valid latency
        base = rx_log.size();
        fe0 = fe_cnt;
        send_frame(8'hA5, BIT_CLKS, 0);
        check("a5_count", rx_log.size() - base, 1);
        check("a5_byte", rx_log[base], 8'hA5);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_data_valid, 1'b1);
        check("a5_latency", rise_cyc - t_start, VALID_LAT);
        check("a5_fe", fe_cnt - fe0, 0);
        do_ack();
        check("a5_ack_clears", rx_data_valid, 1'b0);

        // Start-bit glitch of 20 clocks
        base = rx_log.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        b0 = busy_cnt;
        line_hold(1'b0, 20);
        line_hold(1'b1, 100);
        check("glitch_busy_le34", ((busy_cnt - b0) > 0) && ((busy_cnt - b0) <= 34), 1'b1);
        check("glitch_count", rx_log.size() - base, 0);
        check("glitch_valid", rx_data_valid, 1'b0);
        check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("glitch_idle", busy, 1'b0);

        // Framing error then recovery
        base = rx_log.size();
        fe0 = fe_cnt;
        send_frame(8'h3C, BIT_CLKS, 3);
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_valid", rx_data_valid, 1'b0);
        check("ferr_count", rx_log.size() - base, 0);
        send_frame(8'h81, BIT_CLKS, 0);
        check("after_ferr_count", rx_log.size() - base, 1);
        check("after_ferr_byte", rx_log[base], 8'h81);
        check("after_ferr_fe", fe_cnt - fe0, 1);
        do_ack();

        // Overrun
        base = rx_log.size();
        ov0 = ov_cnt;
        send_frame(8'h11, BIT_CLKS, 0);
        send_frame(8'h22, BIT_CLKS, 0);
        check("ovr_count", rx_log.size() - base, 2);
        check("ovr_first", rx_log[base], 8'h11);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid", rx_data_valid, 1'b1);
        check("ovr_pulses", ov_cnt - ov0, 1);
        do_ack();
        check("ovr_ack_clears", rx_data_valid, 1'b0);
        do_ack();
        check("ack_when_empty", rx_data_valid, 1'b0);

        // Reset in the middle of an 0xFF frame
        base = rx_log.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        line_hold(1'b0, BIT_CLKS);
        line_hold(1'b1, 2 * BIT_CLKS);
        check("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_data_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_flags", {frame_err, overrun_err}, 2'b00);
        rst = 1'b0;
        line_hold(1'b1, 8 * BIT_CLKS);
        send_frame(8'h5A, BIT_CLKS, 0);
        check("midrst_count", rx_log.size() - base, 1);
        check("midrst_byte", rx_log[base], 8'h5A);
        check("midrst_noflags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        do_ack();

        // Bit period sweep at about +/-3 percent
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int pi = 0; pi < 2; pi++) begin
            for (int bi = 0; bi < 2; bi++) begin
                base = rx_log.size();
                send_frame(pats[bi], periods[pi], 0);
                check($sformatf("sweep_p%0d_count", periods[pi]), rx_log.size() - base, 1);
                check($sformatf("sweep_p%0d_byte", periods[pi]), rx_log[base], pats[bi]);
                do_ack();
            end
        end
        check("sweep_noflags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // Error pulses never last more than one clock
        check("fe_single_clk", fe_dbl, 0);
        check("ov_single_clk", ov_dbl, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
